seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_if.sv | 14 +
 rtl/seg_scan_driver.sv | 89 ++++++++
 tb/tb_seg_scan_driver.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: digit-selector handshake and display pins of the scan driver
interface seg_scan_driver_if;
    logic        en;
    logic [2:0]  light;
    logic [10:0] num;
    logic        dot;
    logic [7:0]  blink_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    modport master (input en, num, dot, blink_mask, output light, an, seg, dp, frame_done);
    modport slave (output en, num, dot, blink_mask, input light, an, seg, dp, frame_done);
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment scanner with dead cycle; optional blink via SEG_BLINK_EN
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input logic clk,
    input logic rst_n,
    seg_scan_driver_if.master bus
);
    localparam int SW = $clog2(SCAN_DIV);
    logic [SW-1:0] presc;
    logic          tick;
    logic          load;
    logic [7:0]    an_r;
    logic [6:0]    seg_dec;
    assign tick = bus.en && presc == SW'(SCAN_DIV - 1);
    // Slot prescaler, frozen while disabled
    always_ff @(posedge clk) begin
        if (!rst_n) presc <= '0;
        else if (bus.en) presc <= tick ? '0 : presc + 1'b1;
    end
    // Slot sequencing: tick blanks the digits, the following cycle loads the new slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.light      <= 3'd0;
            an_r           <= 8'hFF;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
            load           <= 1'b1;
        end else begin
            bus.frame_done <= tick && bus.light == 3'd7;
            if (!bus.en) begin
                an_r <= 8'hFF;
                load <= 1'b1;
            end else if (tick) begin
                bus.light <= bus.light + 3'd1;
                an_r      <= 8'hFF;
                load      <= 1'b1;
            end else if (load) begin
                bus.seg <= seg_dec;
                bus.dp  <= ~bus.dot;
                an_r    <= ~(8'd1 << bus.light);
                load    <= 1'b0;
            end
        end
    end
    // Active-low gfedcba decode; dash lights g only, everything else is blank
    always_comb begin
        case (bus.num)
            11'd0:   seg_dec = 7'h40;
            11'd1:   seg_dec = 7'h79;
            11'd2:   seg_dec = 7'h24;
            11'd3:   seg_dec = 7'h30;
            11'd4:   seg_dec = 7'h19;
            11'd5:   seg_dec = 7'h12;
            11'd6:   seg_dec = 7'h02;
            11'd7:   seg_dec = 7'h78;
            11'd8:   seg_dec = 7'h00;
            11'd9:   seg_dec = 7'h10;
            11'd11:  seg_dec = 7'h3F;
            default: seg_dec = 7'h7F;
        endcase
    end
`ifdef SEG_BLINK_EN
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] bcnt;
    logic          hidden;
    // Blink half-period counter; hidden phase masks the selected digits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcnt   <= '0;
            hidden <= 1'b0;
        end else if (bus.en) begin
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt   <= '0;
                hidden <= ~hidden;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end
    assign bus.an = an_r | (hidden ? bus.blink_mask : 8'h00);
`else
    logic unused_mask;
    assign unused_mask = ^bus.blink_mask;
    assign bus.an = an_r;
`endif
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: table-driven and scoreboard checks of seg_scan_driver with SCAN_DIV=4, BLINK_DIV=8
module tb_seg_scan_driver;
    typedef struct {
        logic [2:0] light;
        logic [7:0] an;
        logic [6:0] seg;
        logic       chk_seg;
        logic       fd;
    } exp_t;
    typedef struct {
        logic [10:0] num;
        logic        dot;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [10:0] num_tbl [8];
    logic        dot_tbl [8];
    int total = 0;
    int bad = 0;
    exp_t sq[$];
    vec_t dq[$];
    vec_t vecs[9];
    seg_scan_driver_if bus();
    seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // Digit selector: combinational return of the requested slot
    always_comb begin
        bus.num = num_tbl[bus.light];
        bus.dot = dot_tbl[bus.light];
    end
    function automatic logic [6:0] tdec(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            11: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask
    task automatic wait_light(input logic [2:0] l);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.light == l;
        end
        chk("wait_light", 32'(ok), 32'd1);
    endtask
    initial begin
        exp_t e;
        vec_t v;
        int k;
        int edges;
        bit ok;
        vecs = '{
            '{11'd0, 1'b0, 7'h40, 1'b1}, '{11'd8, 1'b0, 7'h00, 1'b1},
            '{11'd11, 1'b0, 7'h3F, 1'b1}, '{11'd12, 1'b1, 7'h7F, 1'b0},
            '{11'd15, 1'b0, 7'h7F, 1'b1}, '{11'd1, 1'b1, 7'h79, 1'b0},
            '{11'd10, 1'b0, 7'h7F, 1'b1}, '{11'd7, 1'b0, 7'h78, 1'b1},
            '{11'd2047, 1'b1, 7'h7F, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            num_tbl[i] = 11'(i);
            dot_tbl[i] = 1'b0;
        end
        bus.en = 1'b1;
        bus.blink_mask = 8'h01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_light", 32'(bus.light), 32'd0);
        chk("rst_an", 32'(bus.an), 32'hFF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_fd", 32'(bus.frame_done), 32'd0);
        rst_n = 1'b1;
        for (int n = 0; n < 64; n++) begin
            k = n + 1;
            e.light = 3'((k / 4) % 8);
            e.chk_seg = (k % 4) != 0;
            e.an = e.chk_seg ? ~(8'd1 << e.light) : 8'hFF;
`ifdef SEG_BLINK_EN
            if ((k / 8) % 2 == 1) e.an = e.an | 8'h01;
`endif
            e.seg = tdec(int'(e.light));
            e.fd = (k % 32) == 0;
            sq.push_back(e);
            @(posedge clk);
            @(negedge clk);
            e = sq.pop_front();
            chk("scan_light", 32'(bus.light), 32'(e.light));
            chk("scan_an", 32'(bus.an), 32'(e.an));
            chk("scan_fd", 32'(bus.frame_done), 32'(e.fd));
            if (e.chk_seg) chk("scan_seg", 32'(bus.seg), 32'(e.seg));
        end
        bus.blink_mask = 8'h00;
        foreach (vecs[j]) begin
            for (int i = 0; i < 8; i++) begin
                num_tbl[i] = vecs[j].num;
                dot_tbl[i] = vecs[j].dot;
            end
            dq.push_back(vecs[j]);
            ok = 1'b0;
            for (int i = 0; i < 10 && !ok; i++) begin
                @(negedge clk);
                ok = bus.an == 8'hFF;
            end
            chk("dec_dead_seen", 32'(ok), 32'd1);
            @(negedge clk);
            v = dq.pop_front();
            chk("dec_seg", 32'(bus.seg), 32'(v.seg));
            chk("dec_dp", 32'(bus.dp), 32'(v.dp));
        end
        for (int i = 0; i < 8; i++) begin
            num_tbl[i] = 11'(i);
            dot_tbl[i] = 1'b0;
        end
        wait_light(3'd3);
        @(negedge clk);
        chk("en_pre_an", 32'(bus.an), 32'hF7);
        bus.en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("en_off_an", 32'(bus.an), 32'hFF);
            chk("en_off_light", 32'(bus.light), 32'd3);
            chk("en_off_fd", 32'(bus.frame_done), 32'd0);
        end
        bus.en = 1'b1;
        @(negedge clk);
        chk("en_on_an", 32'(bus.an), 32'hF7);
        chk("en_on_seg", 32'(bus.seg), 32'h30);
        chk("en_on_light", 32'(bus.light), 32'd3);
        chk("en_on_fd", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        chk("en_on2_light", 32'(bus.light), 32'd3);
        wait_light(3'd5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_light", 32'(bus.light), 32'd0);
        chk("mid_rst_an", 32'(bus.an), 32'hFF);
        chk("mid_rst_seg", 32'(bus.seg), 32'h7F);
        chk("mid_rst_fd", 32'(bus.frame_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_slot0_an", 32'(bus.an), 32'hFE);
        chk("mid_slot0_seg", 32'(bus.seg), 32'h40);
        edges = 1;
        while (bus.light != 3'd1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("mid_first_tick", 32'(edges), 32'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
